// File: rtl/mem_stage_ctrl_if.sv
// mem_stage_ctrl_if: M-stage operands and data-memory handshake bundle
interface mem_stage_ctrl_if;
  logic [15:0] aluFinalM, wrtDataM, memDataOut, memAddr, memDataIn, readDataM;
  logic memWrtM, readEnM, memAccessM, memDone, memRd, memWr, Stall, err;
  modport master (
    input  aluFinalM, wrtDataM, memWrtM, readEnM, memAccessM, memDataOut, memDone,
    output memAddr, memDataIn, memRd, memWr, readDataM, Stall, err
  );
  modport slave (
    output aluFinalM, wrtDataM, memWrtM, readEnM, memAccessM, memDataOut, memDone,
    input  memAddr, memDataIn, memRd, memWr, readDataM, Stall, err
  );
endinterface

// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl: M-stage memory handshake, stall and sticky error; MEM_ALIGN_CHECK_EN enables odd-address rejection
module mem_stage_ctrl #(
  parameter int MAX_WAIT = 64
) (
  input logic clk,
  input logic rst,
  mem_stage_ctrl_if.master bus
);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t state_q;
  logic [7:0] wait_q;
  logic [15:0] rdata_q;
  logic err_q, rd_q;
  logic misalign, busy, issue, timeout, rd_d;
`ifdef MEM_ALIGN_CHECK_EN
  assign misalign = bus.memAccessM & bus.aluFinalM[0];
`else
  logic unused_acc;
  assign unused_acc = bus.memAccessM;
  assign misalign = 1'b0;
`endif
  // issue/timeout decode; in BUSY the latched read flag decides capture
  always_comb begin
    busy = state_q == BUSY;
    issue = !busy && (bus.readEnM || bus.memWrtM) && !misalign;
    timeout = busy && !bus.memDone && wait_q == 8'(MAX_WAIT - 1);
    rd_d = busy ? rd_q : bus.readEnM;
  end
  assign bus.memAddr = bus.aluFinalM;
  assign bus.memDataIn = bus.wrtDataM;
  assign bus.memRd = !rst && issue && bus.readEnM;
  assign bus.memWr = !rst && issue && !bus.readEnM;
  assign bus.Stall = !rst && (issue || busy) && !bus.memDone && !timeout;
  assign bus.readDataM = rst ? 16'h0 : bus.memDone ? bus.memDataOut : rdata_q;
  assign bus.err = err_q;
  // access FSM: wait counter, load-data capture and sticky error
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      wait_q <= 8'd0;
      rdata_q <= 16'h0;
      err_q <= 1'b0;
      rd_q <= 1'b0;
    end else begin
      if (issue && !bus.memDone) state_q <= BUSY;
      else if (busy && (bus.memDone || timeout)) state_q <= IDLE;
      if (issue) begin
        wait_q <= 8'd0;
        rd_q <= bus.readEnM;
      end else if (busy) wait_q <= wait_q + 8'd1;
      if ((issue || busy) && bus.memDone && rd_d) rdata_q <= bus.memDataOut;
      if (timeout || (!busy && misalign)) err_q <= 1'b1;
    end
  end
endmodule

// File: tb/tb_mem_stage_ctrl.sv
// tb_mem_stage_ctrl: randomized transaction-level check of mem_stage_ctrl
module tb_mem_stage_ctrl;
  localparam int MW = 4;
`ifdef MEM_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  mem_stage_ctrl_if bus();
  mem_stage_ctrl #(.MAX_WAIT(MW)) dut (.clk(clk), .rst(rst), .bus(bus));
  int checks = 0, errors = 0;
  int n_stall = 0, n_rd = 0, n_wr = 0;
  logic e_rd = 0, e_wr = 0, e_stall = 0, e_err = 0;
  logic [15:0] e_rdata = 0, e_addr = 0, e_din = 0;
  logic [15:0] m_rdata = 0;
  logic m_err = 0;
  task automatic chk(string name, logic [15:0] act, logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  always @(negedge clk) begin
    chk("memRd", 16'(bus.memRd), 16'(e_rd));
    chk("memWr", 16'(bus.memWr), 16'(e_wr));
    chk("Stall", 16'(bus.Stall), 16'(e_stall));
    chk("err", 16'(bus.err), 16'(e_err));
    chk("readDataM", bus.readDataM, e_rdata);
    chk("memAddr", bus.memAddr, e_addr);
    chk("memDataIn", bus.memDataIn, e_din);
    n_stall += int'(bus.Stall);
    n_rd += int'(bus.memRd);
    n_wr += int'(bus.memWr);
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(logic rd, logic wr, logic acc, logic [15:0] a, logic [15:0] d, logic dn, logic [15:0] o);
    bus.readEnM = rd;
    bus.memWrtM = wr;
    bus.memAccessM = acc;
    bus.aluFinalM = a;
    bus.wrtDataM = d;
    bus.memDone = dn;
    bus.memDataOut = o;
    e_addr = a;
    e_din = d;
  endtask
  task automatic set_idle_exp(logic dn, logic [15:0] o);
    e_rd = 0;
    e_wr = 0;
    e_stall = 0;
    e_err = m_err;
    e_rdata = dn ? o : m_rdata;
  endtask
  task automatic idle(logic stray);
    logic [15:0] o;
    o = 16'($urandom);
    drive(0, 0, 0, 16'($urandom), 16'($urandom), stray, o);
    set_idle_exp(stray, o);
    step();
  endtask
  task automatic idle_pin(logic [15:0] rd_lit, logic err_lit);
    drive(0, 0, 0, 16'($urandom), 16'($urandom), 0, 16'($urandom));
    set_idle_exp(0, 16'h0);
    #2;
    chk("pin_rdata", bus.readDataM, rd_lit);
    chk("pin_err", 16'(bus.err), 16'(err_lit));
    step();
  endtask
  task automatic do_reset(int n);
    rst = 1'b1;
    drive(0, 0, 0, 16'($urandom), 16'($urandom), 1'($urandom), 16'($urandom));
    m_rdata = 0;
    m_err = 0;
    e_rd = 0;
    e_wr = 0;
    e_stall = 0;
    e_err = 0;
    e_rdata = 0;
    repeat (n) step();
    rst = 1'b0;
  endtask
  // one M-stage access whose memDone arrives k cycles after issue (k > MW never completes)
  task automatic txn(logic rd, logic wr, logic [15:0] a, logic [15:0] d, int k, logic [15:0] dout);
    int last;
    logic [15:0] o;
    if (ALIGN && a[0]) begin
      drive(rd, wr, 1, a, d, 0, 16'($urandom));
      set_idle_exp(0, 16'h0);
      step();
      m_err = 1;
      return;
    end
    last = (k <= MW) ? k : MW;
    for (int i = 0; i <= last; i++) begin
      o = (i == k) ? dout : 16'($urandom);
      drive(rd, wr, 1, a, d, i == k, o);
      e_rd = (i == 0) && rd;
      e_wr = (i == 0) && !rd;
      e_stall = i < last;
      e_err = m_err;
      e_rdata = (i == k) ? o : m_rdata;
      step();
    end
    if (k > MW) m_err = 1;
    else if (rd) m_rdata = dout;
  endtask
  initial begin
    int s0, r0, w0;
    drive(0, 0, 0, 16'h0, 16'h0, 0, 16'h0);
    do_reset(2);
    idle_pin(16'h0000, 1'b0);
    s0 = n_stall; r0 = n_rd;
    txn(1, 0, 16'h0010, 16'h0, 0, 16'hBEEF);
    chk("t1_stall", 16'(n_stall - s0), 16'd0);
    chk("t1_rd", 16'(n_rd - r0), 16'd1);
    idle_pin(16'hBEEF, 1'b0);
    s0 = n_stall; r0 = n_rd;
    txn(1, 0, 16'h0020, 16'h0, 3, 16'h1234);
    chk("t2_stall", 16'(n_stall - s0), 16'd3);
    chk("t2_rd", 16'(n_rd - r0), 16'd1);
    idle_pin(16'h1234, 1'b0);
    s0 = n_stall; w0 = n_wr;
    txn(0, 1, 16'h0040, 16'hA5A5, 1, 16'h5555);
    chk("t3_stall", 16'(n_stall - s0), 16'd1);
    chk("t3_wr", 16'(n_wr - w0), 16'd1);
    idle_pin(16'h1234, 1'b0);
    r0 = n_rd;
    txn(1, 0, 16'h0031, 16'h0, 1, 16'h7777);
    chk("t5_rd", 16'(n_rd - r0), ALIGN ? 16'd0 : 16'd1);
    idle_pin(ALIGN ? 16'h1234 : 16'h7777, ALIGN);
    s0 = n_stall;
    txn(1, 0, 16'h0050, 16'h0, MW + 3, 16'h9999);
    chk("t4_stall", 16'(n_stall - s0), 16'(MW));
    idle_pin(ALIGN ? 16'h1234 : 16'h7777, 1'b1);
    txn(1, 0, 16'h0052, 16'h0, 1, 16'h4242);
    idle_pin(16'h4242, 1'b1);
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 1, 16'h0060, 16'h0, 0, 16'($urandom));
      e_rd = (i == 0);
      e_wr = 0;
      e_stall = 1;
      e_err = m_err;
      e_rdata = m_rdata;
      step();
    end
    do_reset(2);
    drive(0, 0, 0, 16'h0060, 16'h0, 1, 16'hCAFE);
    set_idle_exp(1, 16'hCAFE);
    step();
    idle_pin(16'h0000, 1'b0);
    for (int n = 0; n < 300; n++) begin
      logic rd, wr;
      repeat ($urandom_range(0, 2)) idle(1'($urandom_range(0, 1)));
      if (n % 97 == 50) do_reset(1);
      rd = 1'($urandom);
      wr = rd ? 1'($urandom) : 1'b1;
      txn(rd, wr, 16'($urandom), 16'($urandom), int'($urandom_range(0, MW + 2)), 16'($urandom));
    end
    idle(0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_stage_ctrl.md
# mem_stage_ctrl

Memory-stage controller sitting directly downstream of the execute/memory pipeline register. It consumes the M-stage address, store data and read/write enables, drives a variable-latency data memory through a request/done handshake, and raises `Stall` back to the execute/memory register and upstream stages while an access is outstanding. It presents load data to the memory/writeback register in the cycle the access completes, and flags misaligned or timed-out accesses on a sticky error output.

## Interface
- `MAX_WAIT`, 64: cycles an access may remain outstanding before timeout; legal range 2..255.
- `clk`  in  1  clock, all state on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `aluFinalM`  in  16  memory address from execute/memory register
- `wrtDataM`  in  16  store data
- `memWrtM`  in  1  store request
- `readEnM`  in  1  load request
- `memAccessM`  in  1  instruction is a memory access (alignment qualifier)
- `memDataOut`  in  16  read data from data memory
- `memDone`  in  1  memory completion strobe, one cycle
- `memAddr`  out  16  address to memory, equals `aluFinalM`
- `memDataIn`  out  16  store data to memory, equals `wrtDataM`
- `memRd`  out  1  read request pulse
- `memWr`  out  1  write request pulse
- `readDataM`  out  16  load data to memory/writeback register
- `Stall`  out  1  hold execute/memory register and upstream
- `err`  out  1  sticky error (misaligned or timeout)

## Operation
- States: IDLE, BUSY. Internal 8-bit `waitCnt`, 16-bit `readDataQ`, sticky `errQ`.
- Access = `readEnM | memWrtM`; `readEnM` takes priority if both asserted (read issued, write ignored).
- IDLE, access, not misaligned: `memRd`/`memWr` = 1 this cycle only; `waitCnt` cleared. If `memDone` same cycle: complete, stay IDLE. Else go BUSY.
- BUSY: `memRd`/`memWr` = 0 (no reissue). On `memDone`: complete, go IDLE. Else if `waitCnt == MAX_WAIT-1`: timeout, set `errQ`, go IDLE. Else `waitCnt` increments.
- Completion of a read: `readDataQ <= memDataOut`.
- `readDataM = memDone ? memDataOut : readDataQ`.
- `Stall` = 1 in IDLE-issue cycle without `memDone`, and in every BUSY cycle without `memDone` and not timing out; 0 otherwise.
- `memDone` in IDLE with no outstanding issue: ignored (no capture, no state change).
- `err` = `errQ`; cleared only by `rst`.

## Timing
- Reset (async): state IDLE, `waitCnt` 0, `readDataQ` 0, `errQ` 0. While `rst` high, `Stall`, `memRd`, `memWr` forced 0 and `readDataM` = 0.
- Issue at cycle T, `memDone` at T+k (k ≥ 0): `Stall` high for exactly k cycles (T..T+k-1), low at T+k; `readDataM` valid at T+k; next instruction enters M at T+k+1.
- Timeout: `Stall` high T..T+MAX_WAIT-1, low at T+MAX_WAIT; `err` visible from T+MAX_WAIT+1; `readDataM` keeps previous `readDataQ`.
- `memAddr`/`memDataIn` combinational pass-through; stable during stall because upstream holds.
- Reset asserted mid-BUSY: access abandoned, returns IDLE immediately; a late `memDone` after reset is ignored.

## Configuration
- `MEM_ALIGN_CHECK_EN` defined: in IDLE, `memAccessM & aluFinalM[0]` is misaligned: no request issued, no stall, `errQ` set at end of that cycle, instruction proceeds.
- Not defined: bit 0 not checked; every access issued with address unchanged; `err` reflects timeouts only.

## Test plan
- Load addr 0x0010, `memDone` same cycle with `memDataOut`=0xBEEF -> `memRd` 1 cycle, `Stall` never high, `readDataM`=0xBEEF that cycle.
- Load addr 0x0020, `memDone` 3 cycles after issue, data 0x1234 -> `Stall` high exactly 3 cycles, `memRd` pulsed once, `readDataM`=0x1234 on done cycle and held after.
- Store 0xA5A5 to 0x0040, done after 1 cycle -> `memWr` 1 cycle, `memDataIn`=0xA5A5, `Stall` 1 cycle, `readDataQ` unchanged.
- `MAX_WAIT`=4, load, no `memDone` -> `Stall` high 4 cycles, `err`=1 from fifth cycle after issue, stays 1 through later good accesses.
- With `MEM_ALIGN_CHECK_EN`, load addr 0x0031 with `memAccessM`=1 -> no `memRd`, no stall, `err`=1 next cycle; without macro -> `memRd` issued to 0x0031, `err` 0.
- Load issued, `rst` pulsed 2 cycles into BUSY, then `memDone` -> all outputs 0 during reset, state IDLE after, late `memDone` causes no capture and no stall.
